// File: rtl/mux_pin_bank.sv
// Bank of NUM_CH registered 2:1 mux channels routed onto NUM_PINS bidirectional pads.
// The pin mapping lives in a shadow set and is committed through an IDLE/TRI/LOAD sequence.
module mux_pin_bank #(
  parameter int NUM_PINS    = 12,
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TRI_CYCLES  = 2,
  parameter int PW          = $clog2(NUM_PINS),
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_dir,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [2:0]          cfg_field,
  input  logic [PW-1:0]       cfg_pin,
  input  logic                cfg_commit,
  output logic                cfg_busy,
  output logic                cfg_err
);

  localparam int TCW = (TRI_CYCLES > 1) ? $clog2(TRI_CYCLES) : 1;

  typedef logic [PW-1:0] pin_t;
  typedef enum logic [1:0] {ST_IDLE, ST_TRI, ST_LOAD} state_e;

  state_e              state_q, state_d;
  logic [TCW-1:0]      cnt_q, cnt_d;
  logic                err_q, err_d;

  pin_t                sh_d0_q  [NUM_CH];
  pin_t                sh_d1_q  [NUM_CH];
  pin_t                sh_sel_q [NUM_CH];
  pin_t                sh_out_q [NUM_CH];
  logic [NUM_CH-1:0]   sh_en_q;

  pin_t                act_d0_q  [NUM_CH];
  pin_t                act_d1_q  [NUM_CH];
  pin_t                act_sel_q [NUM_CH];
  pin_t                act_out_q [NUM_CH];
  logic [NUM_CH-1:0]   act_en_q;

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_last;
  logic [NUM_CH-1:0]   ch_q, ch_d;

  logic                wr_ok, wr_err, load_err;
  logic [NUM_CH-1:0]   en_eff;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    wr_ok  = cfg_we && (state_q == ST_IDLE) && (32'(cfg_ch) < NUM_CH)
             && (32'(cfg_pin) < NUM_PINS) && (cfg_field <= 3'd4);
    wr_err = cfg_we && !wr_ok;
  end

  // A channel that would drive one of its own input pins is kept disabled.
  always_comb begin
    load_err = 1'b0;
    en_eff   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sh_en_q[k]) begin
        if ((sh_out_q[k] == sh_d0_q[k]) || (sh_out_q[k] == sh_d1_q[k]) ||
            (sh_out_q[k] == sh_sel_q[k]))
          load_err = 1'b1;
        else
          en_eff[k] = 1'b1;
      end
    end
    for (int k = 1; k < NUM_CH; k++)
      for (int j = 0; j < k; j++)
        if (en_eff[j] && en_eff[k] && (sh_out_q[j] == sh_out_q[k]))
          load_err = 1'b1;
  end

  always_comb begin
    ch_d = '0;
    if (state_q != ST_LOAD)
      for (int k = 0; k < NUM_CH; k++)
        if (act_en_q[k])
          ch_d[k] = sync_last[act_sel_q[k]] ? sync_last[act_d1_q[k]] : sync_last[act_d0_q[k]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_d = ST_TRI;
          cnt_d   = '0;
        end
      end
      ST_TRI: begin
        if (32'(cnt_q) == TRI_CYCLES - 1) state_d = ST_LOAD;
        else                               cnt_d   = cnt_q + TCW'(1);
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    err_d = err_q | wr_err | ((state_q == ST_LOAD) & load_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ch_q     <= '0;
      sh_en_q  <= '0;
      act_en_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        sh_d0_q[k]   <= pin_t'(3*k);
        sh_d1_q[k]   <= pin_t'(3*k + 1);
        sh_sel_q[k]  <= pin_t'(3*k + 2);
        sh_out_q[k]  <= pin_t'(3*NUM_CH + k);
        act_d0_q[k]  <= pin_t'(3*k);
        act_d1_q[k]  <= pin_t'(3*k + 1);
        act_sel_q[k] <= pin_t'(3*k + 2);
        act_out_q[k] <= pin_t'(3*NUM_CH + k);
      end
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_ok && (32'(cfg_ch) == k)) begin
          case (cfg_field)
            3'd0:    sh_d0_q[k]  <= cfg_pin;
            3'd1:    sh_d1_q[k]  <= cfg_pin;
            3'd2:    sh_sel_q[k] <= cfg_pin;
            3'd3:    sh_out_q[k] <= cfg_pin;
            3'd4:    sh_en_q[k]  <= cfg_pin[0];
            default: ;
          endcase
        end
      end
      if (state_q == ST_LOAD) begin
        act_d0_q  <= sh_d0_q;
        act_d1_q  <= sh_d1_q;
        act_sel_q <= sh_sel_q;
        act_out_q <= sh_out_q;
        act_en_q  <= en_eff;
      end
    end
  end

  // Walk channels high to low so the lowest index wins a shared out pin.
  always_comb begin
    pin_dir = '1;
    pin_out = '0;
    if (state_q == ST_IDLE) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (act_en_q[k]) begin
          pin_dir[act_out_q[k]] = 1'b0;
          pin_out[act_out_q[k]] = ch_q[k];
        end
      end
    end
  end

  assign cfg_busy = (state_q != ST_IDLE);
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_mux_pin_bank.sv
// Scoreboard bench for mux_pin_bank: a per-edge reference model queues the expected
// pad/status outputs and a negedge monitor compares them against the DUT.
module tb_mux_pin_bank;

  localparam int NP = 12;
  localparam int NC = 3;
  localparam int SS = 2;
  localparam int TC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pin_in;
  logic [NP-1:0] pin_out;
  logic [NP-1:0] pin_dir;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [2:0]    cfg_field;
  logic [3:0]    cfg_pin;
  logic          cfg_commit;
  logic          cfg_busy;
  logic          cfg_err;

  always #5 clk = ~clk;

  mux_pin_bank #(
    .NUM_PINS(NP), .NUM_CH(NC), .SYNC_STAGES(SS), .TRI_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_field(cfg_field), .cfg_pin(cfg_pin),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: shadow (m_*) and active (a_*) mappings as plain integers,
  // a history of sampled pad values, and a count of remaining busy cycles.
  int            m_d0[NC], m_d1[NC], m_sel[NC], m_out[NC];
  bit            m_en[NC];
  int            a_d0[NC], a_d1[NC], a_sel[NC], a_out[NC];
  bit            a_en[NC];
  bit [NP-1:0]   m_hist[SS];
  bit            m_val[NC];
  int            m_busy_left;
  bit            m_err;
  bit [NP-1:0]   m_smp, m_edir, m_eout;
  logic [25:0]   exp_q[$];
  logic [25:0]   mon_e;

  function automatic void m_reset();
    for (int k = 0; k < NC; k++) begin
      m_d0[k] = 3*k; m_d1[k] = 3*k + 1; m_sel[k] = 3*k + 2; m_out[k] = 3*NC + k;
      m_en[k] = 1'b0;
      a_d0[k] = 3*k; a_d1[k] = 3*k + 1; a_sel[k] = 3*k + 2; a_out[k] = 3*NC + k;
      a_en[k] = 1'b0;
      m_val[k] = 1'b0;
    end
    for (int s = 0; s < SS; s++) m_hist[s] = '0;
    m_busy_left = 0;
    m_err = 1'b0;
  endfunction

  function automatic void m_load();
    bit eff[NC];
    for (int k = 0; k < NC; k++) begin
      eff[k] = m_en[k] && (m_out[k] != m_d0[k]) && (m_out[k] != m_d1[k]) && (m_out[k] != m_sel[k]);
      if (m_en[k] && !eff[k]) m_err = 1'b1;
    end
    for (int j = 0; j < NC; j++)
      for (int k = j + 1; k < NC; k++)
        if (eff[j] && eff[k] && (m_out[j] == m_out[k])) m_err = 1'b1;
    for (int k = 0; k < NC; k++) begin
      a_d0[k] = m_d0[k]; a_d1[k] = m_d1[k]; a_sel[k] = m_sel[k]; a_out[k] = m_out[k];
      a_en[k] = eff[k];
      m_val[k] = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
    end else begin
      m_smp = m_hist[SS-1];
      for (int k = 0; k < NC; k++)
        m_val[k] = (m_busy_left != 1) && a_en[k] &&
                   (m_smp[a_sel[k]] ? m_smp[a_d1[k]] : m_smp[a_d0[k]]);
      if (cfg_we) begin
        if (m_busy_left > 0 || int'(cfg_ch) >= NC || int'(cfg_pin) >= NP) m_err = 1'b1;
        else begin
          case (cfg_field)
            3'd0: m_d0[cfg_ch]  = int'(cfg_pin);
            3'd1: m_d1[cfg_ch]  = int'(cfg_pin);
            3'd2: m_sel[cfg_ch] = int'(cfg_pin);
            3'd3: m_out[cfg_ch] = int'(cfg_pin);
            3'd4: m_en[cfg_ch]  = cfg_pin[0];
            default: m_err = 1'b1;
          endcase
        end
      end
      if (m_busy_left == 1) begin
        m_load();
        m_busy_left = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (cfg_commit) begin
        m_busy_left = TC + 1;
      end
      for (int s = SS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = pin_in;
    end
    m_edir = '1;
    m_eout = '0;
    if (m_busy_left == 0)
      for (int k = 0; k < NC; k++)
        if (a_en[k] && m_edir[a_out[k]]) begin
          m_edir[a_out[k]] = 1'b0;
          m_eout[a_out[k]] = m_val[k];
        end
    exp_q.push_back({m_busy_left != 0, m_err, m_edir, m_eout});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({cfg_busy, cfg_err, pin_dir, pin_out} !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got busy=%b err=%b dir=%h out=%h, want busy=%b err=%b dir=%h out=%h",
                 $time, cfg_busy, cfg_err, pin_dir, pin_out,
                 mon_e[25], mon_e[24], mon_e[23:12], mon_e[11:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int fld, input int pin);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_field = 3'(fld);
    cfg_pin   = 4'(pin);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!cfg_busy) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_idle: cfg_busy still %b after 20 cycles, want 0", cfg_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int nb;

  initial begin
    rst = 1'b1; pin_in = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_field = '0;
    cfg_pin = '0; cfg_commit = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_dir", pin_dir, 12'hFFF);
    chk("rst_out", pin_out, 12'h000);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_err", cfg_err, 1'b0);

    // Empty commit: three busy cycles, pads released throughout.
    commit();
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cfg_busy) break;
      chk("busy_dir", pin_dir, 12'hFFF);
      nb++;
      tick();
    end
    chk("commit_latency", nb, TC + 1);
    chk("empty_dir", pin_dir, 12'hFFF);
    chk("empty_err", cfg_err, 1'b0);

    // Enable ch0: sel=0 selects din0 (pin 0).
    pin_in = 12'h001;
    wr(0, 4, 1);
    commit();
    wait_idle();
    repeat (3) tick();
    chk("ch0_dir9", pin_dir[9], 1'b0);
    chk("ch0_out9", pin_out[9], 1'b1);
    pin_in[2] = 1'b1;
    repeat (2) tick();
    chk("ch0_out9_hold", pin_out[9], 1'b1);
    tick();
    chk("ch0_out9_sel", pin_out[9], 1'b0);

    // Remap ch1 from pin 10 to pin 4 (din1 moved off pin 4 first).
    wr(1, 4, 1);
    commit();
    wait_idle();
    repeat (3) tick();
    chk("ch1_dir10", pin_dir[10], 1'b0);
    wr(1, 1, 0);
    wr(1, 3, 4);
    commit();
    chk("tri_dir10", pin_dir[10], 1'b1);
    chk("tri_dir4", pin_dir[4], 1'b1);
    wait_idle();
    chk("remap_dir4", pin_dir[4], 1'b0);
    chk("remap_dir10", pin_dir[10], 1'b1);
    chk("remap_err", cfg_err, 1'b0);

    // ch0 and ch2 both on pin 11: ch0 wins, error is sticky.
    pin_in = 12'h001;
    wr(2, 4, 1);
    wr(0, 3, 11);
    commit();
    wait_idle();
    repeat (3) tick();
    chk("share_dir11", pin_dir[11], 1'b0);
    chk("share_out11", pin_out[11], 1'b1);
    chk("share_err", cfg_err, 1'b1);
    wr(0, 3, 9);
    commit();
    wait_idle();
    chk("sticky_err", cfg_err, 1'b1);

    // Out-of-range pin write is dropped and flagged.
    do_reset();
    wr(0, 0, 13);
    chk("badpin_err", cfg_err, 1'b1);
    wr(0, 4, 1);
    commit();
    wait_idle();
    repeat (3) tick();
    chk("badpin_shadow", pin_out[9], 1'b1);

    // Write during a commit is dropped and flagged.
    do_reset();
    commit();
    wr(0, 4, 1);
    chk("busy_we_err", cfg_err, 1'b1);
    wait_idle();
    repeat (3) tick();
    chk("busy_we_dir", pin_dir, 12'hFFF);

    // Reset while in TRI aborts the commit.
    wr(0, 4, 1);
    commit();
    wait_idle();
    wr(1, 4, 1);
    commit();
    do_reset();
    chk("rst_tri_busy", cfg_busy, 1'b0);
    chk("rst_tri_dir", pin_dir, 12'hFFF);
    commit();
    wait_idle();
    repeat (3) tick();
    chk("rst_tri_shadow", pin_dir, 12'hFFF);

    // Randomised traffic, checked by the scoreboard.
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 249) == 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_ch     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, NC - 1));
      cfg_field  = 3'($urandom_range(0, 4));
      cfg_pin    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(NP, 15))
                                               : 4'($urandom_range(0, NP - 1));
      cfg_commit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) pin_in = NP'($urandom);
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_pin_bank.md
Name: mux_pin_bank

Overview:
- Parametrised, registered successor to the fixed-pin 2:1 mux wrapper: NUM_CH independent 2:1 mux channels routed onto a bank of NUM_PINS bidirectional pins.
- Per-channel pin mapping and enable are runtime-configurable through a shadow/commit register interface.
- Commits run a contention-safe FSM: all pins are released to input before the new mapping takes effect.
- Sits between the top-level pad ring (pinN / pinN_dir) and the test logic.

Parameters:
- NUM_PINS, 12, number of bank pins; must be >= 4*NUM_CH.
- NUM_CH, 3, number of mux channels.
- SYNC_STAGES, 2, input synchroniser depth; minimum 1.
- TRI_CYCLES, 2, cycles all pins are held as inputs during a commit; minimum 1.
- PW, $clog2(NUM_PINS), pin index width (derived).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- pin_in  input  NUM_PINS  pad input values.
- pin_out  output  NUM_PINS  pad drive values.
- pin_dir  output  NUM_PINS  per-pin direction: 1 = input, 0 = output (pad driven).
- cfg_we  input  1  write strobe into the shadow mapping.
- cfg_ch  input  $clog2(NUM_CH)  target channel.
- cfg_field  input  3  0=din0 pin, 1=din1 pin, 2=sel pin, 3=out pin, 4=enable (cfg_pin[0]).
- cfg_pin  input  PW  pin index or enable value.
- cfg_commit  input  1  one-cycle pulse: apply the shadow mapping.
- cfg_busy  output  1  commit in progress.
- cfg_err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst high at a clk edge):
  - Shadow and active mapping both set to: ch k din0=3k, din1=3k+1, sel=3k+2, out=3*NUM_CH+k; all channels disabled.
  - pin_dir all 1; pin_out all 0; cfg_busy 0; cfg_err 0; synchronisers 0; FSM to IDLE.
  - Reset mid-commit aborts the commit; the shadow mapping is also reset.
- Datapath:
  - pin_in passes through a SYNC_STAGES flop chain.
  - Per enabled channel, result is reg <= sel ? din1 : din0, using synced values at the active mapping indices.
  - Pin change to pin_out change = SYNC_STAGES+1 cycles.
- Output drive:
  - pin_dir[p]=0 and pin_out[p]=channel reg only when p is the out pin of an enabled channel and FSM is IDLE.
  - Otherwise pin_dir[p]=1 and pin_out[p]=0.
- Out-pin conflicts:
  - Two enabled channels sharing an out pin: the lowest channel index drives.
  - Conflict detected at commit LOAD sets cfg_err.
  - An enabled channel whose out pin equals any of its own din0/din1/sel pins sets cfg_err; that channel stays disabled in the active set.
- Config writes:
  - cfg_we in IDLE updates the shadow field the same cycle (visible next cycle).
  - cfg_pin >= NUM_PINS or cfg_ch >= NUM_CH: write ignored, cfg_err set.
  - cfg_we while cfg_busy: ignored, cfg_err set.
  - cfg_we and cfg_commit in the same IDLE cycle: the write lands first, and the commit uses the updated shadow.
- FSM (IDLE, TRI, LOAD):
  - IDLE: on cfg_commit go to TRI; cfg_busy=1 from the next cycle.
  - TRI: all pin_dir=1, pin_out=0; a counter runs TRI_CYCLES cycles, then goes to LOAD.
  - LOAD: 1 cycle; active <= shadow; conflict check; channel output regs cleared to 0; go to IDLE.
  - First valid mux output appears SYNC_STAGES+1 cycles after LOAD.
  - cfg_commit while busy: ignored, no error.
  - Commit latency IDLE to IDLE = TRI_CYCLES+1 busy cycles.
- Disabled channels never drive; their regs hold 0.

Test Plan:
- Reset, then commit with no writes -> 3 busy cycles; pin_dir=12'hFFF throughout and after (all channels disabled); cfg_err=0.
- Enable ch0 (field 4, pin 1) and commit; pin_in[0]=1, pin_in[1]=0, pin_in[2]=0 -> pin_dir[9]=0, pin_out[9]=1 after 3 cycles; set pin_in[2]=1 -> pin_out[9]=0 after exactly 3 cycles.
- Remap ch1 out to pin 4, enabled, while ch1 is driving pin 10 -> on commit pin_dir[10]=1 in TRI; after LOAD pin_dir[4]=0 and pin_dir[10]=1; never both 0.
- ch0 and ch2 both enabled with out=11 -> ch0 drives pin 11, cfg_err=1, remains 1 after further good commits.
- cfg_we with cfg_pin=13 -> shadow unchanged, cfg_err=1; cfg_we during busy -> ignored, cfg_err=1.
- rst asserted in the TRI state -> next cycle cfg_busy=0, pin_dir all 1, mapping back to default, all channels disabled.
